// File: rtl/rv32_debug_pkg.sv
// rv32_debug_pkg: shared run-mode, halt-cause and run-controller state encodings
package rv32_debug_pkg;
    typedef enum logic [1:0] {
        RUN_MODE_FREE  = 2'd0,
        RUN_MODE_STEP  = 2'd1,
        RUN_MODE_BREAK = 2'd2,
        RUN_MODE_RSVD  = 2'd3
    } run_mode_e;
    typedef enum logic [2:0] {
        HALT_NONE       = 3'd0,
        HALT_STEP       = 3'd1,
        HALT_BREAKPOINT = 3'd2,
        HALT_REQUEST    = 3'd3,
        HALT_TIMEOUT    = 3'd4
    } halt_cause_e;
    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_IDLE       = 2'd1,
        ST_RUN        = 2'd2,
        ST_HALTED     = 2'd3
    } run_state_e;
endpackage

// File: rtl/breakpoint_match_rv32.sv
// breakpoint_match_rv32: live pc comparison against all enabled breakpoint entries
module breakpoint_match_rv32 #(
    parameter int PC_WIDTH        = 32,
    parameter int NUM_BREAKPOINTS = 2
) (
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [NUM_BREAKPOINTS*PC_WIDTH-1:0] breakpoint_addr,
    input  logic [NUM_BREAKPOINTS-1:0]          breakpoint_valid,
    output logic                                hit
);
    logic [NUM_BREAKPOINTS-1:0] match;
    for (genvar i = 0; i < NUM_BREAKPOINTS; i++) begin : g_cmp
        assign match[i] = breakpoint_valid[i] && pc == breakpoint_addr[i*PC_WIDTH +: PC_WIDTH];
    end
    assign hit = |match;
endmodule

// File: rtl/run_control_rv32.sv
// run_control_rv32: holds the core in reset, then gates core_enable by free-run/step/breakpoint mode
module run_control_rv32
    import rv32_debug_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int COUNTER_WIDTH   = 32,
    parameter int NUM_BREAKPOINTS = 2,
    parameter int RESET_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES  = 50
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [1:0]                          mode,
    input  logic [COUNTER_WIDTH-1:0]            step_count,
    input  logic                                halt_request,
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [NUM_BREAKPOINTS*PC_WIDTH-1:0] breakpoint_addr,
    input  logic [NUM_BREAKPOINTS-1:0]          breakpoint_valid,
    output logic                                core_reset,
    output logic                                core_enable,
    output logic                                halted,
    output logic [2:0]                          halt_cause,
    output logic [COUNTER_WIDTH-1:0]            cycle_count
);
    localparam int HOLD_W = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;

    run_state_e               state, state_next;
    run_mode_e                run_mode, mode_next;
    halt_cause_e              cause, cause_next, stop_cause;
    logic [HOLD_W-1:0]        hold_count, hold_next;
    logic [COUNTER_WIDTH-1:0] remaining, remaining_next, count_next;
    logic                     suppress, suppress_next, enable_next;
    logic                     hit, bp_stop, step_stop, timeout_stop;

    breakpoint_match_rv32 #(
        .PC_WIDTH       (PC_WIDTH),
        .NUM_BREAKPOINTS(NUM_BREAKPOINTS)
    ) u_match (
        .pc              (pc),
        .breakpoint_addr (breakpoint_addr),
        .breakpoint_valid(breakpoint_valid),
        .hit             (hit)
    );

    // suppress masks a breakpoint on the pc we just resumed from
    assign bp_stop      = run_mode == RUN_MODE_BREAK && hit && !suppress;
    assign step_stop    = run_mode == RUN_MODE_STEP && remaining == COUNTER_WIDTH'(1);
    assign timeout_stop = TIMEOUT_CYCLES != 0 &&
                          cycle_count + COUNTER_WIDTH'(1) == COUNTER_WIDTH'(TIMEOUT_CYCLES);
    assign stop_cause   = halt_request ? HALT_REQUEST :
                          bp_stop      ? HALT_BREAKPOINT :
                          step_stop    ? HALT_STEP :
                          timeout_stop ? HALT_TIMEOUT : HALT_NONE;
    assign halted       = state == ST_HALTED;
    assign halt_cause   = cause;

    always_comb begin
        state_next     = state;
        mode_next      = run_mode;
        cause_next     = cause;
        hold_next      = hold_count;
        remaining_next = remaining;
        count_next     = cycle_count;
        suppress_next  = suppress;
        enable_next    = 1'b0;
        case (state)
            ST_RESET_HOLD: begin
                hold_next  = hold_count + HOLD_W'(1);
                state_next = hold_count == HOLD_W'(RESET_CYCLES - 1) ? ST_IDLE : ST_RESET_HOLD;
            end
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    mode_next      = run_mode_e'(mode);
                    remaining_next = step_count;
                    count_next     = '0;
                    suppress_next  = state == ST_HALTED;
                    if (mode == RUN_MODE_STEP && step_count == '0) begin
                        state_next = ST_HALTED;
                        cause_next = HALT_STEP;
                    end else begin
                        state_next  = ST_RUN;
                        cause_next  = HALT_NONE;
                        enable_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                count_next     = &cycle_count ? cycle_count : cycle_count + COUNTER_WIDTH'(1);
                remaining_next = run_mode == RUN_MODE_STEP ? remaining - COUNTER_WIDTH'(1) : remaining;
                suppress_next  = 1'b0;
                state_next     = stop_cause != HALT_NONE ? ST_HALTED : ST_RUN;
                cause_next     = stop_cause;
                enable_next    = stop_cause == HALT_NONE;
            end
            default: state_next = ST_RESET_HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_RESET_HOLD;
            run_mode    <= RUN_MODE_FREE;
            cause       <= HALT_NONE;
            hold_count  <= '0;
            remaining   <= '0;
            cycle_count <= '0;
            suppress    <= 1'b0;
            core_enable <= 1'b0;
            core_reset  <= 1'b1;
        end else begin
            state       <= state_next;
            run_mode    <= mode_next;
            cause       <= cause_next;
            hold_count  <= hold_next;
            remaining   <= remaining_next;
            cycle_count <= count_next;
            suppress    <= suppress_next;
            core_enable <= enable_next;
            core_reset  <= state_next == ST_RESET_HOLD;
        end
    end
endmodule

// File: tb/tb_run_control_rv32.sv
// tb_run_control_rv32: table, directed and randomized checks of run_control_rv32
module tb_run_control_rv32;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] step_count = '0;
    logic        halt_request = 1'b0;
    logic [31:0] pc = '0;
    logic [63:0] breakpoint_addr = '0;
    logic [1:0]  breakpoint_valid = '0;
    logic        core_reset, core_enable, halted;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] pcs [256];
    bit          hrs [256];

    typedef struct {
        logic [1:0]  m;
        int          s;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [1:0]  bv;
        int          hr_at;
        int          exp_n;
        int          exp_c;
    } vec_t;
    vec_t vecs [13];

    run_control_rv32 #(
        .PC_WIDTH(32), .COUNTER_WIDTH(32), .NUM_BREAKPOINTS(2), .RESET_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .step_count(step_count),
        .halt_request(halt_request), .pc(pc), .breakpoint_addr(breakpoint_addr),
        .breakpoint_valid(breakpoint_valid), .core_reset(core_reset), .core_enable(core_enable),
        .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
        mode = m;
        step_count = s;
        halt_request = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Reference: first enabled cycle k at which any stop rule fires, cause by priority.
    function automatic void model(input logic [1:0] m, input int s, input logic [31:0] b0,
                                  input logic [31:0] b1, input logic [1:0] bv, input bit resumed,
                                  output int n, output int c);
        bit bp;
        n = 0;
        c = 1;
        if (m == 2'd1 && s == 0) return;
        for (int k = 1; k < 256; k++) begin
            bp = m == 2'd2 && !(resumed && k == 1) &&
                 ((bv[0] && pcs[k] == b0) || (bv[1] && pcs[k] == b1));
            c = hrs[k] ? 3 : bp ? 2 : (m == 2'd1 && k == s) ? 1 : (k == 50) ? 4 : 0;
            if (c != 0) begin
                n = k;
                return;
            end
        end
    endfunction

    task automatic apply(input string name, input logic [1:0] m, input logic [31:0] s,
                         input logic [31:0] b0, input logic [31:0] b1, input logic [1:0] bv,
                         input int exp_n, input int exp_c);
        int n = 0;
        breakpoint_addr = {b1, b0};
        breakpoint_valid = bv;
        pulse_start(m, s);
        while (core_enable && n < 200) begin
            n++;
            pc = pcs[n];
            halt_request = hrs[n];
            @(negedge clock);
        end
        halt_request = 1'b0;
        check({name, " enabled_cycles"}, n, exp_n);
        check({name, " halted"}, halted, 1);
        check({name, " halt_cause"}, halt_cause, exp_c);
        check({name, " cycle_count"}, cycle_count, exp_n);
        @(negedge clock);
        check({name, " holds"}, {core_enable, halt_cause, cycle_count}, {1'b0, 3'(exp_c), 32'(exp_n)});
    endtask

    initial begin
        int hn;
        int n;
        vecs[0]  = '{2'd1, 5,  32'h0,  32'h0,  2'b00, 0,  5,  1};
        vecs[1]  = '{2'd1, 0,  32'h0,  32'h0,  2'b00, 0,  0,  1};
        vecs[2]  = '{2'd2, 0,  32'h0,  32'h10, 2'b10, 0,  5,  2};
        vecs[3]  = '{2'd0, 0,  32'h0,  32'h0,  2'b00, 0,  50, 4};
        vecs[4]  = '{2'd2, 0,  32'h0,  32'h10, 2'b10, 5,  5,  3};
        vecs[5]  = '{2'd3, 3,  32'h0,  32'h0,  2'b00, 7,  7,  3};
        vecs[6]  = '{2'd1, 60, 32'h0,  32'h0,  2'b00, 0,  50, 4};
        vecs[7]  = '{2'd0, 0,  32'h10, 32'h10, 2'b11, 20, 20, 3};
        vecs[8]  = '{2'd2, 0,  32'h8,  32'h10, 2'b01, 0,  3,  2};
        vecs[9]  = '{2'd1, 1,  32'h0,  32'h0,  2'b00, 0,  1,  1};
        vecs[10] = '{2'd1, 10, 32'h10, 32'h10, 2'b11, 0,  10, 1};
        vecs[11] = '{2'd2, 0,  32'h0,  32'h0,  2'b01, 0,  50, 4};
        vecs[12] = '{2'd1, 50, 32'h0,  32'h0,  2'b00, 0,  50, 1};

        @(negedge clock);
        check("reset core_reset", core_reset, 1);
        check("reset outputs", {core_enable, halted, halt_cause, cycle_count}, 0);
        reset = 1'b0;
        hn = 0;
        while (core_reset && hn < 20) begin
            hn++;
            @(negedge clock);
        end
        check("reset hold cycles", hn, 4);
        check("idle outputs", {core_enable, halted, halt_cause}, 0);

        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < 256; k++) begin
                pcs[k] = 32'(4 * (k - 1));
                hrs[k] = k == vecs[i].hr_at && k != 0;
            end
            apply($sformatf("vec%0d", i), vecs[i].m, vecs[i].s, vecs[i].b0, vecs[i].b1,
                  vecs[i].bv, vecs[i].exp_n, vecs[i].exp_c);
        end

        // breakpoint at 0x10 with a core whose pc stalls when enable drops, then resume past it
        pc = '0;
        breakpoint_addr = {32'h10, 32'h0};
        breakpoint_valid = 2'b10;
        pulse_start(2'd2, 0);
        n = 0;
        while (core_enable && n < 60) begin
            n++;
            @(negedge clock);
            if (core_enable) pc += 4;
        end
        check("bp stop cycles", n, 5);
        check("bp stop pc", pc, 32'h10);
        check("bp cause", halt_cause, 2);
        check("bp cycle_count", cycle_count, 5);
        pulse_start(2'd2, 0);
        n = 0;
        while (core_enable && n < 60) begin
            n++;
            start = n == 2;
            mode = 2'd1;
            step_count = 1;
            halt_request = n == 4;
            @(negedge clock);
            if (core_enable) pc += 4;
        end
        start = 1'b0;
        halt_request = 1'b0;
        check("resume cycles", n, 4);
        check("resume cause", halt_cause, 3);
        check("resume cycle_count", cycle_count, 4);

        for (int r = 0; r < 40; r++) begin
            logic [1:0] m;
            logic [31:0] s, b0, b1;
            logic [1:0] bv;
            int en, ec;
            m = 2'($urandom_range(0, 3));
            s = $urandom_range(0, 3) == 0 ? $urandom_range(40, 60) : $urandom_range(0, 12);
            b0 = 32'($urandom_range(0, 15) * 4);
            b1 = 32'($urandom_range(0, 15) * 4);
            bv = 2'($urandom_range(0, 3));
            for (int k = 0; k < 256; k++) begin
                pcs[k] = 32'($urandom_range(0, 15) * 4);
                hrs[k] = $urandom_range(0, 19) == 0;
            end
            model(m, int'(s), b0, b1, bv, 1'b1, en, ec);
            apply($sformatf("rand%0d", r), m, s, b0, b1, bv, en, ec);
        end

        hrs = '{default: 1'b0};
        pulse_start(2'd0, 0);
        repeat (6) @(negedge clock);
        check("midrun enabled", {core_enable, cycle_count}, {1'b1, 32'd6});
        reset = 1'b1;
        @(negedge clock);
        check("midrun reset outputs", {core_enable, halted, halt_cause, cycle_count}, 0);
        check("midrun core_reset", core_reset, 1);
        reset = 1'b0;
        hn = 0;
        while (core_reset && hn < 20) begin
            hn++;
            start = hn <= 2;
            @(negedge clock);
        end
        start = 1'b0;
        check("midrun hold cycles", hn, 4);
        @(negedge clock);
        check("start ignored in hold", {core_enable, halted}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
